// File: rtl/fractal_sync_pkg.sv
// Shared types and helpers for the fractal synchronization register files.
// The counting local RF takes its configuration and register widths from here.
package fractal_sync_pkg;

    typedef struct packed {
        int unsigned n_arrive;
        int unsigned timeout_cycles;
    } cnt_rf_cfg_t;

    function automatic int unsigned cnt_width(input int unsigned n);
        return $clog2(n + 1);
    endfunction

    // Age counts 0..timeout_cycles-1; keep at least one bit when aging is disabled.
    function automatic int unsigned age_width(input int unsigned timeout_cycles);
        return (timeout_cycles > 1) ? $clog2(timeout_cycles) : 1;
    endfunction

    function automatic int unsigned age_max(input int unsigned timeout_cycles);
        return (timeout_cycles > 0) ? timeout_cycles - 1 : 0;
    endfunction

endpackage

// File: rtl/fractal_sync_cnt_local_rf_if.sv
// Request/response bundle of the counting local RF.
// The node wrapper is the master; the RF itself is the slave.
interface fractal_sync_cnt_local_rf_if #(
    parameter int unsigned N_REGS   = 4,
    parameter int unsigned ID_WIDTH = 2,
    parameter int unsigned N_PORTS  = 4
);
    logic                              clear_i;
    logic [N_PORTS-1:0][ID_WIDTH-1:0]  id_i;
    logic [N_PORTS-1:0]                check_i;
    logic [N_PORTS-1:0]                present_o;
    logic [N_PORTS-1:0]                id_err_o;
    logic [N_PORTS-1:0]                bypass_o;
    logic [N_PORTS-1:0]                ignore_o;
    logic [N_REGS-1:0]                 timeout_o;
    logic [N_REGS-1:0]                 busy_o;

    modport master (
        output clear_i, id_i, check_i,
        input  present_o, id_err_o, bypass_o, ignore_o, timeout_o, busy_o
    );

    modport slave (
        input  clear_i, id_i, check_i,
        output present_o, id_err_o, bypass_o, ignore_o, timeout_o, busy_o
    );
endinterface

// File: rtl/fractal_sync_cnt_rf_entry.sv
// One barrier entry: arrival count plus age register for the partial-barrier timeout.
// Priority: clear, completion, new arrivals, then aging.
module fractal_sync_cnt_rf_entry
    import fractal_sync_pkg::*;
#(
    parameter cnt_rf_cfg_t CFG = '{n_arrive: 2, timeout_cycles: 0},
    localparam int unsigned CNT_W = cnt_width(CFG.n_arrive)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    input  logic [CNT_W-1:0] n_consumed_i,
    input  logic             complete_i,
    output logic [CNT_W-1:0] count_o,
    output logic             busy_o,
    output logic             timeout_o
);
    localparam int unsigned      AGE_W      = age_width(CFG.timeout_cycles);
    localparam logic [AGE_W-1:0] AGE_MAX    = AGE_W'(age_max(CFG.timeout_cycles));
    localparam bit               TIMEOUT_EN = (CFG.timeout_cycles > 0);

    logic [CNT_W-1:0] count_d, count_q;
    logic [AGE_W-1:0] age_d, age_q;
    logic             timeout_d, timeout_q;

    assign busy_o    = (count_q != '0);
    assign count_o   = count_q;
    assign timeout_o = timeout_q;

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        count_d   = count_q;
        age_d     = age_q;
        timeout_d = 1'b0;
        if (clear_i || complete_i) begin
            count_d = '0;
            age_d   = '0;
        end else if (n_consumed_i != '0) begin
            count_d = count_q + n_consumed_i;
            age_d   = '0;
        end else if (TIMEOUT_EN && busy_o) begin
            if (age_q == AGE_MAX) begin
                count_d   = '0;
                age_d     = '0;
                timeout_d = 1'b1;
            end else begin
                age_d = age_q + AGE_W'(1);
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so all entries update together.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q   <= '0;
            age_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            count_q   <= count_d;
            age_q     <= age_d;
            timeout_q <= timeout_d;
        end
    end

endmodule

// File: rtl/fractal_sync_cnt_local_rf.sv
// Counting local register file: N_ARRIVE-party barriers over N_PORTS request ports.
// Ports are ranked per barrier id by index; the first ones needed are consumed, the rest bypass.
module fractal_sync_cnt_local_rf
    import fractal_sync_pkg::*;
#(
    parameter int unsigned N_REGS         = 4,
    parameter int unsigned ID_WIDTH       = 2,
    parameter int unsigned N_PORTS        = 4,
    parameter int unsigned N_ARRIVE       = 2,
    parameter int unsigned TIMEOUT_CYCLES = 0
) (
    input logic                          clk_i,
    input logic                          rst_ni,
    fractal_sync_cnt_local_rf_if.slave   bus
);
    localparam cnt_rf_cfg_t CFG   = '{n_arrive: N_ARRIVE, timeout_cycles: TIMEOUT_CYCLES};
    localparam int unsigned CNT_W = cnt_width(N_ARRIVE);

    logic [CNT_W-1:0]   count      [N_REGS];
    logic [CNT_W-1:0]   n_consumed [N_REGS];
    logic [N_REGS-1:0]  complete;
    logic [N_PORTS-1:0] present, id_err, bypass, ignore;

    // Per entry: how many of the matching ports are absorbed and whether that completes it.
    always_comb begin
        for (int e = 0; e < N_REGS; e++) begin
            int n_match;
            int n_take;
            n_match = 0;
            for (int p = 0; p < N_PORTS; p++) begin
                if (bus.check_i[p] && (int'(bus.id_i[p]) == e)) n_match++;
            end
            n_take = int'(N_ARRIVE) - int'(count[e]);
            if (n_match < n_take) n_take = n_match;
            n_consumed[e] = CNT_W'(n_take);
            complete[e]   = (int'(count[e]) + n_take) == int'(N_ARRIVE);
        end
    end

    // Per port: rank among same-id ports decides consume vs bypass; rank 0 owns a completion.
    always_comb begin
        for (int p = 0; p < N_PORTS; p++) begin
            int e;
            int rank;
            int need;
            present[p] = 1'b0;
            id_err[p]  = 1'b0;
            bypass[p]  = 1'b0;
            ignore[p]  = 1'b0;
            e    = int'(bus.id_i[p]);
            rank = 0;
            need = 0;
            if (bus.check_i[p]) begin
                if (e >= int'(N_REGS)) begin
                    id_err[p] = 1'b1;
                end else begin
                    for (int q = 0; q < p; q++) begin
                        if (bus.check_i[q] && (bus.id_i[q] == bus.id_i[p])) rank++;
                    end
                    need = int'(N_ARRIVE) - int'(count[e]);
                    if (rank >= need)    bypass[p]  = 1'b1;
                    else if (complete[e]) begin
                        if (rank == 0)   present[p] = 1'b1;
                        else             ignore[p]  = 1'b1;
                    end
                end
            end
        end
    end

    for (genvar g = 0; g < N_REGS; g++) begin : g_entry
        fractal_sync_cnt_rf_entry #(
            .CFG (CFG)
        ) u_entry (
            .clk_i        (clk_i),
            .rst_ni       (rst_ni),
            .clear_i      (bus.clear_i),
            .n_consumed_i (n_consumed[g]),
            .complete_i   (complete[g]),
            .count_o      (count[g]),
            .busy_o       (bus.busy_o[g]),
            .timeout_o    (bus.timeout_o[g])
        );
    end

    assign bus.present_o = present;
    assign bus.id_err_o  = id_err;
    assign bus.bypass_o  = bypass;
    assign bus.ignore_o  = ignore;

endmodule

// File: tb/tb_fractal_sync_cnt_local_rf.sv
// Directed bench for the counting local RF: dut_a is a 2-party RF without aging,
// dut_b a 3-party RF with a 4-cycle timeout. Port responses are packed as {present, ignore, bypass, id_err}.
module tb_fractal_sync_cnt_local_rf;

    logic clk = 1'b0;
    logic rst_n;
    int   tests_run    = 0;
    int   tests_failed = 0;

    always #5 clk = ~clk;

    fractal_sync_cnt_local_rf_if #(.N_REGS(4), .ID_WIDTH(3), .N_PORTS(4)) bus_a ();
    fractal_sync_cnt_local_rf_if #(.N_REGS(4), .ID_WIDTH(3), .N_PORTS(4)) bus_b ();

    fractal_sync_cnt_local_rf #(
        .N_REGS(4), .ID_WIDTH(3), .N_PORTS(4), .N_ARRIVE(2), .TIMEOUT_CYCLES(0)
    ) dut_a (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus_a)
    );

    fractal_sync_cnt_local_rf #(
        .N_REGS(4), .ID_WIDTH(3), .N_PORTS(4), .N_ARRIVE(3), .TIMEOUT_CYCLES(4)
    ) dut_b (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus_b)
    );

    function automatic logic [11:0] ids(input int i3, input int i2, input int i1, input int i0);
        return {3'(i3), 3'(i2), 3'(i1), 3'(i0)};
    endfunction

    // Inputs change just after the falling edge; checks run 1 ns later, well away from the rising edge.
    task automatic step_a(input logic [3:0] chk, input logic [11:0] id, input logic clr);
        @(negedge clk);
        bus_a.check_i = chk;
        bus_a.id_i    = id;
        bus_a.clear_i = clr;
        #1;
    endtask

    task automatic step_b(input logic [3:0] chk, input logic [11:0] id);
        @(negedge clk);
        bus_b.check_i = chk;
        bus_b.id_i    = id;
        bus_b.clear_i = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus_a.check_i = '0; bus_a.id_i = ids(1, 2, 3, 1); bus_a.clear_i = 1'b0;
        bus_b.check_i = '0; bus_b.id_i = ids(3, 2, 1, 0); bus_b.clear_i = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        tests_run++;
        if (bus_a.busy_o !== 4'b0000) begin
            tests_failed++; $display("FAIL reset busy_a: got %b expected 0000", bus_a.busy_o);
        end
        tests_run++;
        if ({bus_b.busy_o, bus_b.timeout_o} !== 8'h00) begin
            tests_failed++; $display("FAIL reset busy/timeout_b: got %b expected 00000000", {bus_b.busy_o, bus_b.timeout_o});
        end
        tests_run++;
        if ({bus_a.present_o, bus_a.ignore_o, bus_a.bypass_o, bus_a.id_err_o} !== 16'h0000) begin
            tests_failed++; $display("FAIL reset ports_a idle: got %h expected 0000",
                {bus_a.present_o, bus_a.ignore_o, bus_a.bypass_o, bus_a.id_err_o});
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_two_party();
        step_a(4'b0001, ids(0, 0, 0, 1), 1'b0);
        tests_run++;
        if ({bus_a.present_o, bus_a.ignore_o, bus_a.bypass_o, bus_a.id_err_o} !== 16'h0000) begin
            tests_failed++; $display("FAIL two_party first ports: got %h expected 0000",
                {bus_a.present_o, bus_a.ignore_o, bus_a.bypass_o, bus_a.id_err_o});
        end
        step_a(4'b0000, '0, 1'b0);
        tests_run++;
        if (bus_a.busy_o !== 4'b0010) begin
            tests_failed++; $display("FAIL two_party busy: got %b expected 0010", bus_a.busy_o);
        end
        step_a(4'b0000, '0, 1'b0);
        step_a(4'b0100, ids(0, 1, 0, 0), 1'b0);
        tests_run++;
        if ({bus_a.present_o, bus_a.ignore_o, bus_a.bypass_o, bus_a.id_err_o} !== 16'h4000) begin
            tests_failed++; $display("FAIL two_party complete ports: got %h expected 4000",
                {bus_a.present_o, bus_a.ignore_o, bus_a.bypass_o, bus_a.id_err_o});
        end
        step_a(4'b0000, '0, 1'b0);
        tests_run++;
        if (bus_a.busy_o !== 4'b0000) begin
            tests_failed++; $display("FAIL two_party busy after: got %b expected 0000", bus_a.busy_o);
        end
    endtask

    task automatic test_same_cycle();
        step_a(4'b1011, ids(2, 0, 2, 2), 1'b0);
        tests_run++;
        if ({bus_a.present_o, bus_a.ignore_o, bus_a.bypass_o, bus_a.id_err_o} !== 16'h1280) begin
            tests_failed++; $display("FAIL same_cycle ports: got %h expected 1280",
                {bus_a.present_o, bus_a.ignore_o, bus_a.bypass_o, bus_a.id_err_o});
        end
        // A fresh epoch on id 2 must start from zero: one arrival is only recorded.
        step_a(4'b0010, ids(0, 0, 2, 0), 1'b0);
        tests_run++;
        if ({bus_a.busy_o, bus_a.present_o} !== 8'h00) begin
            tests_failed++; $display("FAIL same_cycle count reset: got %h expected 00", {bus_a.busy_o, bus_a.present_o});
        end
        step_a(4'b0001, ids(0, 0, 0, 2), 1'b0);
        tests_run++;
        if ({bus_a.busy_o, bus_a.present_o} !== 8'h41) begin
            tests_failed++; $display("FAIL same_cycle next epoch: got %h expected 41", {bus_a.busy_o, bus_a.present_o});
        end
        step_a(4'b0000, '0, 1'b0);
    endtask

    task automatic test_id_err();
        step_a(4'b0001, ids(0, 0, 0, 0), 1'b0);
        step_a(4'b1010, ids(7, 0, 5, 0), 1'b0);
        tests_run++;
        if ({bus_a.present_o, bus_a.ignore_o, bus_a.bypass_o, bus_a.id_err_o} !== 16'h000A) begin
            tests_failed++; $display("FAIL id_err ports: got %h expected 000a",
                {bus_a.present_o, bus_a.ignore_o, bus_a.bypass_o, bus_a.id_err_o});
        end
        step_a(4'b0001, ids(0, 0, 0, 0), 1'b0);
        tests_run++;
        if ({bus_a.busy_o, bus_a.present_o} !== 8'h11) begin
            tests_failed++; $display("FAIL id_err no state change: got %h expected 11", {bus_a.busy_o, bus_a.present_o});
        end
        step_a(4'b0000, '0, 1'b0);
    endtask

    task automatic test_clear();
        step_a(4'b0001, ids(0, 0, 0, 1), 1'b0);
        step_a(4'b0010, ids(0, 0, 1, 0), 1'b1);
        tests_run++;
        if ({bus_a.busy_o, bus_a.present_o} !== 8'h22) begin
            tests_failed++; $display("FAIL clear comb answer: got %h expected 22", {bus_a.busy_o, bus_a.present_o});
        end
        step_a(4'b0001, ids(0, 0, 0, 3), 1'b1);
        step_a(4'b0000, '0, 1'b0);
        tests_run++;
        if (bus_a.busy_o !== 4'b0000) begin
            tests_failed++; $display("FAIL clear discards arrival: got %b expected 0000", bus_a.busy_o);
        end
    endtask

    task automatic test_reset_mid();
        step_a(4'b0001, ids(0, 0, 0, 1), 1'b0);
        step_a(4'b0000, '0, 1'b0);
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (bus_a.busy_o !== 4'b0000) begin
            tests_failed++; $display("FAIL reset_mid busy: got %b expected 0000", bus_a.busy_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step_a(4'b0100, ids(0, 1, 0, 0), 1'b0);
        tests_run++;
        if ({bus_a.present_o, bus_a.ignore_o, bus_a.bypass_o, bus_a.id_err_o} !== 16'h0000) begin
            tests_failed++; $display("FAIL reset_mid late arrival: got %h expected 0000",
                {bus_a.present_o, bus_a.ignore_o, bus_a.bypass_o, bus_a.id_err_o});
        end
        step_a(4'b0000, '0, 1'b1);
        step_a(4'b0000, '0, 1'b0);
    endtask

    task automatic test_three_party();
        step_b(4'b0001, ids(0, 0, 0, 0));
        step_b(4'b0110, ids(0, 0, 0, 0));
        tests_run++;
        if ({bus_b.present_o, bus_b.ignore_o, bus_b.bypass_o, bus_b.id_err_o} !== 16'h2400) begin
            tests_failed++; $display("FAIL three_party ports: got %h expected 2400",
                {bus_b.present_o, bus_b.ignore_o, bus_b.bypass_o, bus_b.id_err_o});
        end
        tests_run++;
        if (bus_b.busy_o !== 4'b0001) begin
            tests_failed++; $display("FAIL three_party busy: got %b expected 0001", bus_b.busy_o);
        end
        step_b(4'b0001, ids(0, 0, 0, 1));
        tests_run++;
        if (bus_b.busy_o !== 4'b0000) begin
            tests_failed++; $display("FAIL three_party busy after: got %b expected 0000", bus_b.busy_o);
        end
        // c=1 on id 1: ports 0,1 finish it, ports 2,3 are excess.
        step_b(4'b1111, ids(1, 1, 1, 1));
        tests_run++;
        if ({bus_b.present_o, bus_b.ignore_o, bus_b.bypass_o, bus_b.id_err_o} !== 16'h12C0) begin
            tests_failed++; $display("FAIL three_party bypass ports: got %h expected 12c0",
                {bus_b.present_o, bus_b.ignore_o, bus_b.bypass_o, bus_b.id_err_o});
        end
        step_b(4'b0000, '0);
        tests_run++;
        if (bus_b.busy_o !== 4'b0000) begin
            tests_failed++; $display("FAIL three_party bypass busy: got %b expected 0000", bus_b.busy_o);
        end
    endtask

    task automatic test_timeout();
        logic [3:0] exp_to;
        step_b(4'b0001, ids(0, 0, 0, 3));
        for (int k = 1; k <= 6; k++) begin
            step_b(4'b0000, '0);
            exp_to = (k == 5) ? 4'b1000 : 4'b0000;
            tests_run++;
            if ({bus_b.timeout_o, bus_b.busy_o} !== {exp_to, (k < 5) ? 4'b1000 : 4'b0000}) begin
                tests_failed++; $display("FAIL timeout step %0d: got to/busy %b expected %b", k,
                    {bus_b.timeout_o, bus_b.busy_o}, {exp_to, (k < 5) ? 4'b1000 : 4'b0000});
            end
        end
    endtask

    task automatic test_timeout_rearm();
        step_b(4'b0001, ids(0, 0, 0, 3));
        repeat (3) step_b(4'b0000, '0);
        step_b(4'b0010, ids(0, 0, 3, 0));
        for (int k = 5; k <= 10; k++) begin
            step_b(4'b0000, '0);
            tests_run++;
            if ({bus_b.timeout_o, bus_b.busy_o} !== ((k == 9) ? 8'h80 : (k < 9) ? 8'h08 : 8'h00)) begin
                tests_failed++; $display("FAIL timeout_rearm step %0d: got to/busy %b expected %b", k,
                    {bus_b.timeout_o, bus_b.busy_o}, ((k == 9) ? 8'h80 : (k < 9) ? 8'h08 : 8'h00));
            end
        end
    endtask

    task automatic test_multi_timeout();
        step_b(4'b0011, ids(0, 0, 2, 1));
        for (int k = 1; k <= 5; k++) step_b(4'b0000, '0);
        tests_run++;
        if ({bus_b.timeout_o, bus_b.busy_o} !== 8'h60) begin
            tests_failed++; $display("FAIL multi_timeout: got to/busy %b expected 01100000", {bus_b.timeout_o, bus_b.busy_o});
        end
    endtask

    initial begin
        test_reset();
        test_two_party();
        test_same_cycle();
        test_id_err();
        test_clear();
        test_reset_mid();
        test_three_party();
        test_timeout();
        test_timeout_rearm();
        test_multi_timeout();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
